// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants, types and helpers for the register-file write arbiter.
package rf_arb_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
    // Wide enough for a requester index when NUM_REQ is at most 8.
    localparam int                    PTR_W      = 3;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } rf_wr_t;

    // Pointer after a grant: one past the winner, wrapping at n.
    function automatic logic [PTR_W-1:0] next_rr(input logic [PTR_W-1:0] ptr,
                                                 input logic [PTR_W-1:0] winner,
                                                 input int               n);
        if (int'(winner) >= n) return ptr;
        if (int'(winner) == n - 1) return '0;
        return winner + 1'b1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback-source and register-file write-port bundle for rf_write_arbiter.
interface rf_write_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3
);
    import rf_arb_pkg::*;

    logic                          hold;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          RegWrite;
    logic [REG_ADDR_W-1:0]         W_Add;
    logic [WIDTH-1:0]              W_Data;
    logic                          busy;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, RegWrite, W_Add, W_Data, busy
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, RegWrite, W_Add, W_Data, busy
    );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        if (en) begin
            // Upper segment [ptr, N) first, then the wrapped segment [0, ptr).
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (i >= int'(ptr))) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = PTR_W'(i);
                    any     = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (i < int'(ptr))) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = PTR_W'(i);
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ sources.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  any;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  regwrite_q, regwrite_d;
    logic [REG_ADDR_W-1:0] wadd_q, wadd_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .en      (~bus.hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(gnt_idx) == i) begin
                win_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                win_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A grant is always an acceptance: gnt is only raised on a valid request.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        regwrite_d = 1'b0;
        wadd_d     = wadd_q;
        wdata_d    = wdata_q;
        if (any) begin
            rr_ptr_d   = next_rr(rr_ptr_q, gnt_idx, NUM_REQ);
            regwrite_d = (win_addr != REG_ZERO);
            wadd_d     = win_addr;
            wdata_d    = win_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            regwrite_q <= 1'b0;
            wadd_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            regwrite_q <= regwrite_d;
            wadd_q     <= wadd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.RegWrite  = regwrite_q;
    assign bus.W_Add     = wadd_q;
    assign bus.W_Data    = wdata_q;
    assign bus.busy      = (|bus.req_valid) | regwrite_q;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite, W_Add, W_Data) among NUM_REQ writeback sources, e.g. ALU, load unit and CSR/link writeback.
- Arbitration is round-robin with a valid/ready handshake per requester.
- The write command to the register file is driven from registered outputs, one cycle after acceptance.
- Sits between the writeback sources and the register file; its outputs connect directly to the register file's write port.

Parameters:
- WIDTH, 32, data width of each write (matches the register file width).
- NUM_REQ, 3, number of requesters (2..8).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- hold  in  1  when 1, no requester is granted this cycle (register-file maintenance or debug freeze).
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*5  per-requester destination register, packed; requester i uses bits [5i+4:5i].
- req_data  in  NUM_REQ*WIDTH  per-requester write data, packed the same way.
- req_ready  out  NUM_REQ  one-hot-or-zero grant; the request is accepted when req_valid[i] and req_ready[i] are both 1.
- RegWrite  out  1  write enable to the register file.
- W_Add  out  5  write address to the register file.
- W_Data  out  WIDTH  write data to the register file.
- busy  out  1  1 when any req_valid is high or RegWrite is high.

Behaviour:
- Reset values: RegWrite=0, W_Add=0, W_Data=0, rr_ptr=0, req_ready=0. Reset asserted mid-operation discards the pending output write (RegWrite forced to 0) and returns rr_ptr to 0.
- Grant is combinational within the cycle.
  - If hold=1 or no req_valid is high, req_ready is all zero.
  - Otherwise exactly one req_ready bit is set: the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[i] never asserts without req_valid[i].
- rr_ptr updates only on an accepted request, to (winner+1) mod NUM_REQ.
  - Wrap-around: with winner NUM_REQ-1, rr_ptr becomes 0.
  - rr_ptr is unchanged on idle cycles or while hold=1.
  - Each continuously valid requester is served within NUM_REQ accepted grants; no starvation.
- Output stage, registered, latency 1 cycle from acceptance to RegWrite.
  - Cycle after acceptance: W_Add=req_addr[winner], W_Data=req_data[winner], RegWrite=1 if that address is nonzero, else 0.
  - A write to x0 is accepted (ready given, pointer advances) but produces RegWrite=0. W_Add and W_Data still update to the accepted values.
  - Cycle after a cycle with no acceptance: RegWrite=0; W_Add and W_Data hold their last values.
- Throughput is one write per cycle; back-to-back acceptances give consecutive RegWrite pulses.
- Same destination from two requesters: the writes are serialized in grant order, so the last granted value persists in the register file.
- Requester contract:
  - Once req_valid is raised, req_addr and req_data stay stable until accepted.
  - Dropping req_valid before acceptance is legal and loses nothing, since no state is captured.
  - The arbiter does not check this contract; the verification bench asserts it.
- hold asserted while the output stage holds a write: that write still completes on the next cycle. hold only blocks new grants.
- No combinational path from RegWrite, W_Add or W_Data back to req_ready.

Decomposition:
- Package rf_arb_pkg holds:
  - REG_ADDR_W=5;
  - REG_ZERO=5'd0;
  - typedef rf_wr_t, a struct of logic [REG_ADDR_W-1:0] addr and logic [31:0] data;
  - a function next_rr(ptr, winner, n).
- One sub-module, rr_arbiter, parameterized by N.
  - Inputs: req[N], ptr, en.
  - Outputs: gnt[N] one-hot, gnt_idx, any.
  - Purely combinational.
- The top level holds rr_ptr and the output register.

Test Plan:
- Reset check: assert reset mid-write, with RegWrite=1, W_Add=7, W_Data=0x55 on the output -> RegWrite=0, W_Add=0, W_Data=0 immediately (asynchronous); after release, the first grant goes to requester 0.
- Single request: req0 valid with addr=3, data=0xDEADBEEF at cycle t -> req_ready=3'b001 at t; at t+1 RegWrite=1, W_Add=3, W_Data=0xDEADBEEF; at t+2 RegWrite=0.
- Round-robin with wrap: all three requests held valid (addrs 1, 2, 3) for 6 cycles -> grant order 0,1,2,0,1,2; RegWrite high for 6 consecutive cycles with W_Add 1,2,3,1,2,3.
- x0 write: req1 with addr=0, data=0x1234 -> req_ready[1]=1; next cycle RegWrite=0, W_Data=0x1234; rr_ptr advances to 2, so with req1 and req2 then valid, the next grant goes to req2.
- Hold: hold=1 for 3 cycles with req2 valid -> req_ready=0 and RegWrite=0 throughout, apart from a write already in the output stage completing. Release hold -> req2 granted in the same cycle.
- Same-address conflict: req0 (addr=5, data=0xA) and req1 (addr=5, data=0xB) valid together with rr_ptr=0 -> W_Data 0xA then 0xB; register x5 ends at 0xB.
